// File: rtl/score_pkg.sv
// Shared widths, limits and state encoding for the score tracker and display path.
package score_pkg;

  localparam int unsigned SCORE_W   = 7;
  localparam int unsigned SCORE_MAX = 99;
  localparam int unsigned LIVES_W   = 2;
  localparam int unsigned STATE_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_PLAY  = 2'b01;
  localparam logic [STATE_W-1:0] ST_OVER  = 2'b10;
  localparam logic [STATE_W-1:0] ST_SPARE = 2'b11;

  // Clamp a signed intermediate score into the displayable 0..SCORE_MAX range.
  function automatic logic [SCORE_W-1:0] clamp_score(input logic signed [8:0] v);
    if (v < 9'sd0) begin
      return '0;
    end else if (v > $signed(9'(SCORE_MAX))) begin
      return SCORE_W'(SCORE_MAX);
    end else begin
      return v[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse on a low-to-high transition of level.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level; cleared so a level high at reset release fires once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Score, lives and session high-score tracker feeding the seven-segment display.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned HIT_POINTS    = 1,
  parameter int unsigned CRASH_PENALTY = 2,
  parameter int unsigned LIVES         = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               crash,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] max_score,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               game_over,
  output logic               new_record
);

  localparam logic signed [8:0]    HIT_D      = 9'(HIT_POINTS);
  localparam logic signed [8:0]    CRASH_D    = 9'(CRASH_PENALTY);
  localparam logic [LIVES_W-1:0]   LIVES_INIT = LIVES_W'(LIVES);

  logic                start_ev;
  logic                hit_ev;
  logic                crash_ev;
  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_nx;
  logic signed [8:0]   sum_c;
  logic [SCORE_W-1:0]  next_score;
  logic                end_game;

  edge_detect u_start_ed (.clk(clk), .rst(rst), .level(start), .pulse(start_ev));
  edge_detect u_hit_ed   (.clk(clk), .rst(rst), .level(hit),   .pulse(hit_ev));
  edge_detect u_crash_ed (.clk(clk), .rst(rst), .level(crash), .pulse(crash_ev));

  // Net score delta for this cycle, clamped to the display range.
  always_comb begin
    sum_c = $signed({2'b00, score});
    if (hit_ev) begin
      sum_c = sum_c + HIT_D;
    end
    if (crash_ev) begin
      sum_c = sum_c - CRASH_D;
    end
    next_score = clamp_score(sum_c);
    end_game   = (state == ST_PLAY) && crash_ev && (lives == LIVES_W'(1));
  end

  // Next-state decode; start is only honoured outside PLAY.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_ev) state_nx = ST_PLAY;
      ST_PLAY: if (end_game) state_nx = ST_OVER;
      ST_OVER: if (start_ev) state_nx = ST_PLAY;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Game state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Score, lives and high-score datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score      <= '0;
      max_score  <= '0;
      lives      <= LIVES_INIT;
      new_record <= 1'b0;
    end else if ((state == ST_IDLE || state == ST_OVER) && start_ev) begin
      score      <= '0;
      lives      <= LIVES_INIT;
      new_record <= 1'b0;
    end else if (state == ST_PLAY) begin
      score <= next_score;
      if (crash_ev) begin
        lives <= lives - LIVES_W'(1);
      end
      if (end_game && (next_score > max_score)) begin
        max_score  <= next_score;
        new_record <= 1'b1;
      end
    end
  end

  assign playing   = (state == ST_PLAY);
  assign game_over = (state == ST_OVER);

endmodule
